fifo_burst_reader: RTL

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pops a fixed-length burst of words from an upstream
//               synchronous FIFO (1-cycle read latency), presents each word on
//               a valid/ready output stream, marks the final word, and keeps a
//               modulo-2^N running checksum of the accepted words.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-low reset
//   start      : burst request, sampled only while idle
//   fifo_empty : upstream FIFO empty flag
//   fifo_dout  : upstream FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : upstream FIFO pop strobe
//   m_valid    : output word valid
//   m_ready    : downstream ready
//   m_data     : output word
//   m_last     : final word of the burst (qualified by m_valid)
//   checksum   : modulo-2^N sum of words accepted in the current/last burst
//   busy       : high whenever not idle
//   done       : one-cycle pulse on burst completion
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int N     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         fifo_empty,
    input  logic [N-1:0] fifo_dout,
    output logic         fifo_rd,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         m_last,
    output logic [N-1:0] checksum,
    output logic         busy,
    output logic         done
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_READ = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_SEND = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // Count value held while the final word of the burst is being sent.
    localparam logic [7:0] c_LAST_IDX = 8'(BURST - 1);

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [7:0]   r_count;
    logic [N-1:0] r_checksum;
    logic [N-1:0] r_data;
    logic         w_is_last;
    logic         w_handshake;

    assign w_is_last   = (r_count == c_LAST_IDX);
    assign w_handshake = (r_state == c_SEND) && m_ready;

    assign m_data   = r_data;
    assign checksum = r_checksum;

    always_comb begin
        w_next_state = r_state;
        fifo_rd      = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = c_READ;
                end
            end
            c_READ: begin
                // Pop is gated directly by the empty flag so it can never
                // be issued against an empty FIFO.
                if (!fifo_empty) begin
                    fifo_rd      = 1'b1;
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                w_next_state = c_SEND;
            end
            c_SEND: begin
                m_valid = 1'b1;
                m_last  = w_is_last;
                if (m_ready) begin
                    w_next_state = w_is_last ? c_DONE : c_READ;
                end
            end
            c_DONE: begin
                done         = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_count    <= 8'd0;
            r_checksum <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_IDLE) && start) begin
                r_count    <= 8'd0;
                r_checksum <= '0;
            end
            // FIFO data arrives one cycle after the pop.
            if (r_state == c_WAIT) begin
                r_data <= fifo_dout;
            end
            // The final handshake leaves the count at BURST, so an 8-bit
            // counter cannot wrap for BURST up to 255.
            if (w_handshake) begin
                r_count    <= r_count + 8'd1;
                r_checksum <= r_checksum + r_data;
            end
        end
    end

endmodule
`default_nettype wire
